// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I integer-ALU decode/operand select feeding the ALU through a registered 2-entry skid buffer.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      alu_op,
  output logic [6:0]      alu_subop,
  output logic [XLEN-1:0] alu_oprnd1,
  output logic [XLEN-1:0] alu_oprnd2,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);
  typedef struct packed {
    logic [2:0]      op;
    logic [6:0]      subop;
    logic [XLEN-1:0] o1;
    logic [XLEN-1:0] o2;
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] pc;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state, nxt;
  entry_t dec, main_q, skid_q;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_op, is_imm, is_lui, is_auipc, sh, legal;
  logic acc, la, ld_main, ld_skid, mv_skid;
  assign opc      = in_instr[6:0];
  assign f3       = in_instr[14:12];
  assign f7       = in_instr[31:25];
  assign is_op    = opc == 7'b0110011;
  assign is_imm   = opc == 7'b0010011;
  assign is_lui   = opc == 7'b0110111;
  assign is_auipc = opc == 7'b0010111;
  assign sh       = is_imm && (f3 == 3'b001 || f3 == 3'b101);
  // Only SUB/SRA (OP) and SRAI (OP-IMM) may carry funct7 0100000.
  assign legal = is_op  ? (f7 == 7'b0 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))) :
                 is_imm ? (!sh || f7 == 7'b0 || (f3 == 3'b101 && f7 == 7'b0100000)) :
                 is_lui || is_auipc;
  always_comb begin
    dec.op    = (is_op || is_imm) ? f3 : 3'b0;
    dec.subop = (is_op || sh) ? f7 : 7'b0;
    dec.o1    = is_lui ? '0 : is_auipc ? in_pc : in_rs1_data;
    dec.o2    = is_op  ? in_rs2_data :
                sh     ? {27'b0, in_instr[24:20]} :
                is_imm ? {{20{in_instr[31]}}, in_instr[31:20]} :
                         {in_instr[31:12], 12'b0};
    dec.rd    = in_instr[11:7];
    dec.wen   = |in_instr[11:7];
    dec.pc    = in_pc;
  end
  assign acc = in_valid && in_ready && !flush;
  assign la  = acc && legal;
  always_comb begin
    nxt     = state;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    case (state)
      EMPTY: begin
        ld_main = la;
        nxt     = la ? BUSY : EMPTY;
      end
      BUSY: begin
        ld_main = la && out_ready;
        ld_skid = la && !out_ready;
        nxt     = ld_skid ? FULL : (!la && out_ready) ? EMPTY : BUSY;
      end
      FULL: begin
        mv_skid = out_ready;
        nxt     = out_ready ? BUSY : FULL;
      end
      default: nxt = EMPTY;
    endcase
    if (flush) nxt = EMPTY;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      illegal   <= 1'b0;
      main_q    <= '0;
      skid_q    <= '0;
    end else begin
      state     <= nxt;
      out_valid <= nxt != EMPTY;
      in_ready  <= nxt != FULL;
      illegal   <= acc && !legal;
      if (ld_main) main_q <= dec;
      else if (mv_skid) main_q <= skid_q;
      if (ld_skid) skid_q <= dec;
    end
  end
  assign alu_op     = main_q.op;
  assign alu_subop  = main_q.subop;
  assign alu_oprnd1 = main_q.o1;
  assign alu_oprnd2 = main_q.o2;
  assign out_rd     = main_q.rd;
  assign out_wen    = main_q.wen;
  assign out_pc     = main_q.pc;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based reference of the issue stage.
module tb_alu_issue_stage;
  typedef struct packed {
    logic [2:0]  op;
    logic [6:0]  subop;
    logic [31:0] o1;
    logic [31:0] o2;
    logic [4:0]  rd;
    logic        wen;
    logic [31:0] pc;
  } ent_t;
  logic CLK = 1'b0, RST = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0, in_rs1_data = '0, in_rs2_data = '0;
  logic in_ready, out_valid, out_wen, illegal;
  logic [2:0] alu_op;
  logic [6:0] alu_subop;
  logic [31:0] alu_oprnd1, alu_oprnd2, out_pc;
  logic [4:0] out_rd;
  int checks = 0, errors = 0;
  ent_t q[$];
  logic exp_ill = 1'b0, last_fire = 1'b0;

  alu_issue_stage #(.XLEN(32)) dut (
    .CLK(CLK), .RST(RST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op), .alu_subop(alu_subop),
    .alu_oprnd1(alu_oprnd1), .alu_oprnd2(alu_oprnd2), .out_rd(out_rd), .out_wen(out_wen),
    .out_pc(out_pc), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ent_t ref_ent(input logic [31:0] i, pc, a, b, output logic ok);
    ent_t e;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = i[14:12];
    f7 = i[31:25];
    e = '0;
    ok = 1'b1;
    e.rd = i[11:7];
    e.wen = i[11:7] != 5'd0;
    e.pc = pc;
    case (i[6:0])
      7'b0110011: begin
        e.op = f3; e.subop = f7; e.o1 = a; e.o2 = b;
        ok = f7 == 7'd0 || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'b0010011: begin
        e.op = f3; e.o1 = a;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.subop = f7;
          e.o2 = 32'(i[24:20]);
          ok = f7 == 7'd0 || (f3 == 3'd5 && f7 == 7'b0100000);
        end else e.o2 = 32'($signed(i[31:20]));
      end
      7'b0110111: e.o2 = i & 32'hFFFFF000;
      7'b0010111: begin e.o1 = pc; e.o2 = i & 32'hFFFFF000; end
      default: ok = 1'b0;
    endcase
    return e;
  endfunction

  task automatic cycle();
    ent_t e;
    logic ok, fire;
    @(negedge CLK);
    chk("out_valid", out_valid, q.size() != 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("illegal", illegal, exp_ill);
    if (q.size() != 0)
      chk("fields", {alu_op, alu_subop, alu_oprnd1, alu_oprnd2, out_rd, out_wen, out_pc}, q[0]);
    e = ref_ent(in_instr, in_pc, in_rs1_data, in_rs2_data, ok);
    fire = in_valid && q.size() < 2 && !flush;
    if (q.size() != 0 && out_ready) void'(q.pop_front());
    if (fire && ok) q.push_back(e);
    exp_ill = fire && !ok;
    if (flush) q.delete();
    last_fire = fire;
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] i, p, a, b);
    int k;
    in_valid = 1'b1; in_instr = i; in_pc = p; in_rs1_data = a; in_rs2_data = b;
    k = 0;
    do begin cycle(); k++; end while (!last_fire && k < 50);
    chk("push_accepted", last_fire, 1'b1);
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 5);
    r[6:0] = k == 0 ? 7'b0110011 : k == 1 ? 7'b0010011 : k == 2 ? 7'b0110111 :
             k == 3 ? 7'b0010111 : k == 4 ? 7'b0010011 : r[6:0];
    k = $urandom_range(0, 3);
    if (k == 0) r[31:25] = 7'd0;
    else if (k == 1) r[31:25] = 7'b0100000;
    return r;
  endfunction

  initial begin
    #2 RST = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1'b1);
    chk("rst_zero", {out_valid, illegal, alu_op, alu_subop, alu_oprnd1, alu_oprnd2, out_rd, out_wen, out_pc}, 128'd0);
    @(posedge CLK); #1 RST = 1'b0;
    out_ready = 1'b1;
    cycle();
    push(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk("add_valid", out_valid, 1'b1);
    chk("add_op_subop", {alu_op, alu_subop}, 10'd0);
    chk("add_oprnds", {alu_oprnd1, alu_oprnd2}, {32'd5, 32'd7});
    chk("add_rd_wen", {out_rd, out_wen}, {5'd3, 1'b1});
    push(32'hFFF00093, 32'h4, 32'd9, 32'd0);
    chk("addi_subop", alu_subop, 7'd0);
    chk("addi_oprnd2", alu_oprnd2, 32'hFFFFFFFF);
    push(32'h40335293, 32'h8, 32'h80000000, 32'd1);
    chk("srai_op_subop", {alu_op, alu_subop}, {3'b101, 7'b0100000});
    chk("srai_oprnds", {alu_oprnd1, alu_oprnd2}, {32'h80000000, 32'd3});
    push(32'h12345517, 32'h100, 32'hDEAD, 32'hBEEF);
    chk("auipc_oprnds", {alu_oprnd1, alu_oprnd2}, {32'h100, 32'h12345000});
    chk("auipc_rd", out_rd, 5'd10);
    push(32'h00001037, 32'h104, 32'd1, 32'd2);
    chk("lui_wen", out_wen, 1'b0);
    cycle();
    push(32'h00000073, 32'h108, 32'd0, 32'd0);
    chk("ecall_illegal", {illegal, out_valid}, 2'b10);
    cycle();
    push(32'h02109093, 32'h10C, 32'd1, 32'd1);
    chk("slli_illegal", {illegal, out_valid}, 2'b10);
    cycle();
    push(32'h4020C1B3, 32'h110, 32'd1, 32'd1);
    chk("op_f7_illegal", {illegal, out_valid}, 2'b10);
    cycle();
    out_ready = 1'b0;
    push(32'h002081B3, 32'h200, 32'hA, 32'h1);
    push(32'h402081B3, 32'h204, 32'hB, 32'h2);
    chk("full_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_instr = 32'h0020C1B3; in_pc = 32'h208; in_rs1_data = 32'hC; in_rs2_data = 32'h3;
    cycle();
    cycle();
    out_ready = 1'b1;
    push(32'h0020C1B3, 32'h208, 32'hC, 32'h3);
    repeat (4) cycle();
    out_ready = 1'b0;
    push(32'h00100093, 32'h300, 32'd1, 32'd0);
    push(32'h00200093, 32'h304, 32'd2, 32'd0);
    in_valid = 1'b1; in_instr = 32'h00000073; flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_state", {out_valid, in_ready, illegal}, 3'b010);
    cycle();
    push(32'h00100093, 32'h400, 32'd1, 32'd0);
    push(32'h00200093, 32'h404, 32'd2, 32'd0);
    #2 RST = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 1'b1);
    chk("midrst_zero", {out_valid, illegal, alu_op, alu_subop, alu_oprnd1, alu_oprnd2, out_rd, out_wen, out_pc}, 128'd0);
    q.delete();
    exp_ill = 1'b0;
    @(posedge CLK); #1 RST = 1'b0;
    out_ready = 1'b1;
    cycle();
    for (int n = 0; n < 800; n++) begin
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
      in_instr = rand_instr();
      in_pc = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage directly upstream of the ALU in the RV32I core. It accepts one fetched instruction plus register-file read data per handshake, decodes the integer-ALU class (OP, OP-IMM, LUI, AUIPC), and selects operands. It presents `activate/op/subop/oprnd1/oprnd2` to the ALU from a registered output, behind a 2-entry skid buffer with valid/ready flow control.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all buffered and incoming work.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept; driven from a register.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data  in  32  register-file value for instr[19:15].
- in_rs2_data  in  32  register-file value for instr[24:20].
- out_valid  out  1  issue entry valid; also drives ALU `activate`.
- out_ready  in  1  downstream consumes the entry.
- alu_op  out  3  ALU op (funct3 or 000).
- alu_subop  out  7  ALU subop (0000000 or 0100000 only).
- alu_oprnd1  out  32  first operand.
- alu_oprnd2  out  32  second operand.
- out_rd  out  5  destination register.
- out_wen  out  1  write enable; 0 when rd==0.
- out_pc  out  32  PC of the issued instruction.
- illegal  out  1  one-cycle pulse when an unsupported instruction is consumed.

## Operation
- Accept when `in_valid && in_ready && !flush`.
- OP (0110011): op=funct3; subop=funct7; oprnd1=rs1_data; oprnd2=rs2_data. Legal funct7: 0000000 always. 0100000 is legal only with funct3 000 or 101.
- OP-IMM (0010011): op=funct3; oprnd1=rs1_data.
  - funct3 001 and 101: oprnd2={27'b0, instr[24:20]}; subop=instr[31:25]. Legal subop is 0000000 for 001, and 0000000 or 0100000 for 101.
  - All other funct3: oprnd2=sign-extended instr[31:20]; subop forced to 0000000 (immediate bits never reach subop).
- LUI (0110111): op=000, subop=0, oprnd1=0, oprnd2={instr[31:12],12'b0}.
- AUIPC (0010111): op=000, subop=0, oprnd1=in_pc, oprnd2={instr[31:12],12'b0}.
- rd=instr[11:7]; wen=(rd!=0).
- Any other opcode or illegal funct7:
  - the handshake completes; nothing enters the buffer;
  - `illegal` pulses in the next cycle.
- Buffer FSM (main register drives the outputs; skid register holds overflow):
  - EMPTY: out_valid=0, in_ready=1. Legal accept -> BUSY.
  - BUSY: out_valid=1, in_ready=1.
    - accept and out_ready: main is replaced -> BUSY.
    - accept and !out_ready: new entry goes to skid -> FULL.
    - no accept and out_ready -> EMPTY.
    - otherwise hold.
  - FULL: out_valid=1, in_ready=0. On out_ready, skid moves to main -> BUSY.
- Issue order equals acceptance order. No entry is duplicated or dropped except by flush.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state EMPTY; out_valid=0; in_ready=1; illegal=0;
  - alu_op, alu_subop, alu_oprnd1, alu_oprnd2, out_rd, out_wen, out_pc all 0.
- Latency: accept at edge N -> out_valid and fields valid after edge N. One issue per cycle sustained while out_ready=1.
- There is no combinational path from any input to any output. in_ready and all outputs are register-driven.
- While out_valid=1 and out_ready=0, all output fields hold stable.
- flush has priority over every other event:
  - next state is EMPTY; out_valid=0 and in_ready=1 after the edge;
  - an instruction presented in the flush cycle is discarded, and `illegal` is not pulsed for it;
  - a pending `illegal` pulse from the previous cycle still appears.
- RST mid-stream discards all entries; no partial issue follows.

## Test plan
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, op=000, subop=0000000, oprnd1=5, oprnd2=7, rd=3, wen=1.
- Immediate forms:
  - ADDI x1,x0,-1 (0xFFF00093) -> subop=0000000, oprnd2=0xFFFFFFFF.
  - SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> op=101, subop=0100000, oprnd2=3.
- AUIPC x10,0x12345 (0x12345517) at pc=0x100 -> oprnd1=0x100, oprnd2=0x12345000, rd=10. LUI x0,1 -> wen=0.
- Backpressure:
  - out_ready=0; push A, B, C back-to-back -> A and B accepted, in_ready=0 after B, C held upstream.
  - Raise out_ready -> issues A, B, C in order, each exactly once.
- Illegal cases:
  - 0x00000073 (ECALL) -> `illegal`=1 for one cycle; out_valid stays 0.
  - SLLI with instr[25]=1 -> same response.
  - OP with funct7=0100000 and funct3=100 -> same response.
- flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, `illegal`=0. Assert RST mid-stream -> all outputs zero before the next clock edge.
